// File: rtl/disk2_if.sv
// Disk II soft-switch bus: CPU access strobe/nibble in,
// stepper/motor/latch/head state out.
interface disk2_if;
  logic       io_strobe;
  logic [3:0] addr;
  logic [3:0] phs;
  logic       motor;
  logic       drive2;
  logic       q6;
  logic       q7;
  logic [6:0] halftrack;
  logic       step_pulse;

  modport master (
    output io_strobe, addr,
    input  phs, motor, drive2, q6, q7,
    input  halftrack, step_pulse
  );

  modport slave (
    input  io_strobe, addr,
    output phs, motor, drive2, q6, q7,
    output halftrack, step_pulse
  );
endinterface

// File: rtl/disk2_switches.sv
// Disk II slot-6 soft switches ($C0E0-$C0EF): stepper phases,
// motor with spin-down, drive select, Q6/Q7, half-track head tracking.
// Ports: clk, reset (async high), bus (slave: io_strobe/addr in;
// phs, motor, drive2, q6, q7, halftrack, step_pulse out).
module disk2_switches #(
  parameter int MOTOR_OFF_CYCLES = 14318180,
  parameter int MAX_HALFTRACK    = 69
) (
  input  logic    clk,
  input  logic    reset,
  disk2_if.slave  bus
);
  localparam int CW = $clog2(MOTOR_OFF_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MOTOR_OFF_CYCLES - 1);
  localparam logic [6:0]    HT_MAX   = 7'(MAX_HALFTRACK);

  typedef enum logic [1:0] {
    M_OFF,
    M_ON,
    M_SPIN
  } mstate_e;

  mstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    phs_q, phs_d;
  logic          drive2_q, drive2_d;
  logic          q6_q, q6_d;
  logic          q7_q, q7_d;
  logic          pend_q, pend_d;
  logic [6:0]    ht_q, ht_d;
  logic          pulse_q, pulse_d;

  logic          motor;
  logic          sel_ph;
  logic          is8, is9;
  logic [1:0]    p;
  logic          up, dn;

  assign motor  = (state_q != M_OFF);
  assign sel_ph = bus.io_strobe & ~bus.addr[3];
  assign is8    = bus.io_strobe & (bus.addr == 4'h8);
  assign is9    = bus.io_strobe & (bus.addr == 4'h9);

  // Neighbouring magnets relative to the current half-track;
  // 2-bit arithmetic gives the mod-4 wrap.
  assign p  = ht_q[1:0];
  assign up = phs_q[p + 2'd1] & ~phs_q[p + 2'd3];
  assign dn = phs_q[p + 2'd3] & ~phs_q[p + 2'd1];

  always_comb begin
    phs_d    = phs_q;
    drive2_d = drive2_q;
    q6_d     = q6_q;
    q7_d     = q7_q;
    if (sel_ph) phs_d[bus.addr[2:1]] = bus.addr[0];
    if (bus.io_strobe) begin
      case (bus.addr[3:1])
        3'b101:  drive2_d = bus.addr[0];
        3'b110:  q6_d     = bus.addr[0];
        3'b111:  q7_d     = bus.addr[0];
        default: ;
      endcase
    end
    // Pending lasts exactly one cycle: it is consumed
    // (moved or discarded) in the following cycle.
    pend_d = sel_ph & (phs_d != phs_q);
  end

  always_comb begin
    ht_d    = ht_q;
    pulse_d = 1'b0;
    if (pend_q && motor) begin
      if (up && ht_q < HT_MAX) begin
        ht_d    = ht_q + 7'd1;
        pulse_d = 1'b1;
      end else if (dn && ht_q != 7'd0) begin
        ht_d    = ht_q - 7'd1;
        pulse_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      M_OFF: begin
        if (is9) state_d = M_ON;
      end
      M_ON: begin
        if (is8) begin
          state_d = M_SPIN;
          cnt_d   = CNT_LOAD;
        end
      end
      M_SPIN: begin
        // Motor-on wins over expiry; a repeat motor-off
        // does not reload the count.
        if (is9) begin
          state_d = M_ON;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = M_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = M_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= M_OFF;
      cnt_q    <= '0;
      phs_q    <= '0;
      drive2_q <= 1'b0;
      q6_q     <= 1'b0;
      q7_q     <= 1'b0;
      pend_q   <= 1'b0;
      ht_q     <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phs_q    <= phs_d;
      drive2_q <= drive2_d;
      q6_q     <= q6_d;
      q7_q     <= q7_d;
      pend_q   <= pend_d;
      ht_q     <= ht_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.phs        = phs_q;
  assign bus.motor      = motor;
  assign bus.drive2     = drive2_q;
  assign bus.q6         = q6_q;
  assign bus.q7         = q7_q;
  assign bus.halftrack  = ht_q;
  assign bus.step_pulse = pulse_q;
endmodule

// File: tb/tb_disk2_switches.sv
// Bench for disk2_switches: vector table, directed motor/stepper
// corner sequences and random accesses against a reference model.
module tb_disk2_switches;
  localparam int M    = 16;
  localparam int MAXH = 69;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disk2_if bus ();

  disk2_switches #(
    .MOTOR_OFF_CYCLES(M),
    .MAX_HALFTRACK(MAXH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: motor tracked as mode + absolute
  // cycle at which the spin-down ends.
  logic [3:0] m_phs;
  bit m_d2, m_q6, m_q7, m_pulse, m_pend;
  int m_h, m_mode, m_end;
  int cyc = 0;

  function automatic logic [3:0] new_phs(logic [3:0] cur,
                                         logic [3:0] a);
    logic [3:0] r;
    r = cur;
    r[a[2:1]] = a[0];
    return r;
  endfunction

  function automatic int next_h(int h, logic [3:0] ph);
    int p;
    bit hi, lo;
    p  = h % 4;
    hi = ph[(p + 1) % 4];
    lo = ph[(p + 3) % 4];
    if (hi && !lo && h < MAXH) return h + 1;
    if (lo && !hi && h > 0) return h - 1;
    return h;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phs <= 4'h0; m_d2 <= 0; m_q6 <= 0; m_q7 <= 0;
      m_pulse <= 0; m_pend <= 0; m_h <= 0;
      m_mode <= 0; m_end <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.io_strobe && bus.addr < 4'd8) begin
        m_phs  <= new_phs(m_phs, bus.addr);
        m_pend <= new_phs(m_phs, bus.addr) != m_phs;
      end else begin
        m_pend <= 0;
      end
      if (m_pend && m_mode != 0) begin
        m_h     <= next_h(m_h, m_phs);
        m_pulse <= next_h(m_h, m_phs) != m_h;
      end else begin
        m_pulse <= 0;
      end
      if (bus.io_strobe) begin
        if (bus.addr == 4'hA || bus.addr == 4'hB)
          m_d2 <= bus.addr[0];
        if (bus.addr == 4'hC || bus.addr == 4'hD)
          m_q6 <= bus.addr[0];
        if (bus.addr == 4'hE || bus.addr == 4'hF)
          m_q7 <= bus.addr[0];
      end
      if (m_mode == 0) begin
        if (bus.io_strobe && bus.addr == 4'h9) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (bus.io_strobe && bus.addr == 4'h8) begin
          m_mode <= 2;
          m_end  <= cyc + M;
        end
      end else begin
        if (bus.io_strobe && bus.addr == 4'h9) m_mode <= 1;
        else if (cyc == m_end) m_mode <= 0;
      end
    end
  end

  task automatic compare_model();
    tests++;
    if (bus.phs !== m_phs || bus.motor !== (m_mode != 0) ||
        bus.drive2 !== m_d2 || bus.q6 !== m_q6 ||
        bus.q7 !== m_q7 || bus.halftrack !== 7'(m_h) ||
        bus.step_pulse !== m_pulse) begin
      fails++;
      $display("FAIL model t=%0t got phs=%b mot=%b d2=%b q6=%b q7=%b h=%0d sp=%b want phs=%b mot=%b d2=%b q6=%b q7=%b h=%0d sp=%b",
               $time, bus.phs, bus.motor, bus.drive2, bus.q6,
               bus.q7, bus.halftrack, bus.step_pulse, m_phs,
               m_mode != 0, m_d2, m_q6, m_q7, m_h, m_pulse);
    end
  endtask

  task automatic chk(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic access(logic [3:0] a);
    bus.io_strobe = 1'b1;
    bus.addr      = a;
    tick();
    bus.io_strobe = 1'b0;
  endtask

  task automatic do_reset();
    bus.io_strobe = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    compare_model();
    reset = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (bus.motor === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Walk the head up k half-tracks from "only phase (h%4) on".
  task automatic walk_up(int h0, int k);
    for (int i = 0; i < k; i++) begin
      int p;
      p = (h0 + i) % 4;
      access(4'(2 * ((p + 1) % 4) + 1));
      access(4'(2 * p));
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] a;
    logic [3:0] phs;
    int         h;
    bit         sp;
    bit         mot;
    bit         d2;
    bit         q6;
    bit         q7;
  } vec_t;

  vec_t tab[$];

  initial begin
    int n, lows;
    logic [14:0] got, want;

    reset = 1'b1;
    bus.io_strobe = 1'b0;
    bus.addr = 4'h0;

    tab.push_back('{1, 4'h9, 4'b0000, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h1, 4'b0001, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h3, 4'b0011, 1, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h0, 4'b0010, 1, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h5, 4'b0110, 2, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h2, 4'b0100, 2, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h7, 4'b1100, 3, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h4, 4'b1000, 3, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h5, 4'b1100, 2, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h6, 4'b0100, 2, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h3, 4'b0110, 1, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h4, 4'b0010, 1, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h1, 4'b0011, 0, 1, 1, 0, 0, 0});
    tab.push_back('{0, 4'h2, 4'b0001, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h0, 4'b0000, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 4'h7, 4'b1000, 0, 0, 1, 0, 0, 0});
    tab.push_back('{1, 4'h1, 4'b0001, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h3, 4'b0011, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h0, 4'b0010, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h5, 4'b0110, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h2, 4'b0100, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h7, 4'b1100, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'h4, 4'b1000, 0, 0, 0, 0, 0, 0});
    tab.push_back('{0, 4'hB, 4'b1000, 0, 0, 0, 1, 0, 0});
    tab.push_back('{0, 4'hD, 4'b1000, 0, 0, 0, 1, 1, 0});
    tab.push_back('{0, 4'hF, 4'b1000, 0, 0, 0, 1, 1, 1});
    tab.push_back('{0, 4'hA, 4'b1000, 0, 0, 0, 0, 1, 1});
    tab.push_back('{0, 4'hC, 4'b1000, 0, 0, 0, 0, 0, 1});
    tab.push_back('{0, 4'hE, 4'b1000, 0, 0, 0, 0, 0, 0});

    @(negedge clk);
    compare_model();
    chk("reset_outputs",
        int'({bus.phs, bus.motor, bus.drive2, bus.q6, bus.q7,
              bus.halftrack, bus.step_pulse}), 0);
    reset = 1'b0;

    foreach (tab[i]) begin
      if (tab[i].rst) do_reset();
      access(tab[i].a);
      tick();
      got  = {bus.phs, bus.halftrack, bus.step_pulse,
              bus.motor, bus.drive2, bus.q6, bus.q7};
      want = {tab[i].phs, 7'(tab[i].h), tab[i].sp, tab[i].mot,
              tab[i].d2, tab[i].q6, tab[i].q7};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL vec%0d addr=%h: got %b want %b",
                 i, tab[i].a, got, want);
      end
    end

    // Spin-down length and no restart on repeated motor-off.
    do_reset();
    access(4'h9);
    access(4'h8);
    count_high(n);
    chk("spindown_len", n, M);
    access(4'h9);
    access(4'h8);
    repeat (7) tick();
    access(4'h8);
    count_high(n);
    chk("no_restart", n, M - 8);

    // Motor-on during spin-down aborts it; later full countdown.
    access(4'h9);
    access(4'h8);
    repeat (9) tick();
    access(4'h9);
    lows = 0;
    repeat (30) begin
      tick();
      if (bus.motor !== 1'b1) lows++;
    end
    chk("abort_spindown", lows, 0);
    access(4'h8);
    count_high(n);
    chk("fresh_spindown", n, M);

    // Strobe in the cycle the count expires.
    access(4'h9);
    access(4'h8);
    repeat (M - 1) tick();
    access(4'h9);
    lows = 0;
    repeat (30) begin
      tick();
      if (bus.motor !== 1'b1) lows++;
    end
    chk("expiry_on_wins", lows, 0);
    access(4'h8);
    repeat (M - 1) tick();
    access(4'hB);
    chk("expiry_off_motor", int'(bus.motor), 0);
    chk("expiry_off_drive2", int'(bus.drive2), 1);

    // Clamp at the top half-track.
    do_reset();
    access(4'h9);
    access(4'h1);
    walk_up(0, MAXH);
    tick();
    chk("walk_to_max", int'(bus.halftrack), MAXH);
    access(4'h5);
    tick();
    chk("clamp_max_h", int'(bus.halftrack), MAXH);
    chk("clamp_max_pulse", int'(bus.step_pulse), 0);

    // Async reset in the middle of a spin-down.
    do_reset();
    access(4'h9);
    access(4'h1);
    walk_up(0, 5);
    tick();
    chk("walk_to_5", int'(bus.halftrack), 5);
    access(4'h8);
    count_high(n);
    access(4'h2);
    access(4'h5);
    tick();
    chk("pre_reset_phs", int'(bus.phs), 4);
    chk("pre_reset_h", int'(bus.halftrack), 5);
    access(4'h9);
    access(4'h8);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    compare_model();
    chk("async_reset",
        int'({bus.phs, bus.motor, bus.drive2, bus.q6, bus.q7,
              bus.halftrack, bus.step_pulse}), 0);
    @(negedge clk);
    reset = 1'b0;
    access(4'h9);
    tick();
    chk("post_reset_motor", int'(bus.motor), 1);
    chk("post_reset_h", int'(bus.halftrack), 0);

    // Random accesses against the model.
    do_reset();
    repeat (4000) begin
      if ($urandom_range(600) == 0) do_reset();
      if ($urandom_range(2) == 0) begin
        bus.io_strobe = 1'b1;
        bus.addr = 4'($urandom_range(15));
      end else begin
        bus.io_strobe = 1'b0;
      end
      tick();
    end
    bus.io_strobe = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
